// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Size encodings, FSM state type and default base address.
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic [31:0] DMEM_BASE_ADDR = 32'h0100_0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a 32-bit storage word and a sized access.
// Produces byte enables, replicated write data and extended read data.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] raw,
   output logic [3:0]  byte_en,
   output logic [31:0] wword,
   output logic [31:0] rdata
);

   logic [31:0] shifted;

   // Steer lanes for the requested size and offset
   always_comb begin
      byte_en = 4'b0000;
      wword   = 32'h0;
      rdata   = 32'h0;
      shifted = raw >> {offset, 3'b000};
      unique case (size)
         SIZE_BYTE: begin
            byte_en = 4'b0001 << offset;
            wword   = {4{wdata[7:0]}};
            rdata   = is_unsigned ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
         end
         SIZE_HALF: begin
            byte_en = 4'b0011 << offset;
            wword   = {2{wdata[15:0]}};
            rdata   = is_unsigned ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
         end
         SIZE_WORD: begin
            byte_en = 4'b1111;
            wword   = wdata;
            rdata   = raw;
         end
         default: begin
            byte_en = 4'b0000;
            wword   = 32'h0;
            rdata   = 32'h0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with valid/ready request and response channels.
// Optional DMEM_MISALIGN_CHECK_EN faults unaligned half/word accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
   parameter int          DEPTH_BYTES = 65536,
   parameter int          LATENCY     = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          WORDS = DEPTH_BYTES / 4;
   localparam int          AW    = $clog2(WORDS);
   localparam logic [31:0] DEPTH = 32'(DEPTH_BYTES);

   dmem_state_t state, state_nx;
   logic [3:0]  cnt, cnt_nx;

   logic        q_write;
   logic [31:0] q_addr;
   logic [31:0] q_wdata;
   logic [1:0]  q_size;
   logic        q_uns;

   logic        a_write;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic [1:0]  a_size;
   logic        a_uns;

   logic        accept;
   logic        commit;
   logic [31:0] off;
   logic [1:0]  lane_off;
   logic        range_err;
   logic        size_err;
   logic        mis_err;
   logic        err;
   logic [AW-1:0] idx;
   logic [31:0] raw;
   logic [3:0]  byte_en;
   logic [31:0] wword;
   logic [31:0] rd_ext;

   logic [31:0] mem [WORDS];

   assign req_ready = (state == ST_IDLE) && !reset;
   assign rsp_valid = (state == ST_RESP);
   assign accept    = req_valid && req_ready;
   assign commit    = ((state == ST_WAIT) && (cnt == 4'd0))
                   || ((LATENCY == 0) && accept);

   // A zero-latency commit uses the live request, otherwise the latch
   always_comb begin
      if (state == ST_IDLE) begin
         a_write = req_write;
         a_addr  = req_addr;
         a_wdata = req_wdata;
         a_size  = req_size;
         a_uns   = req_unsigned;
      end else begin
         a_write = q_write;
         a_addr  = q_addr;
         a_wdata = q_wdata;
         a_size  = q_size;
         a_uns   = q_uns;
      end
   end

   assign off       = a_addr - BASE_ADDR;
   assign range_err = (a_addr < BASE_ADDR) || (off >= DEPTH);
   assign size_err  = (a_size == 2'd3);
`ifdef DMEM_MISALIGN_CHECK_EN
   assign mis_err   = ((a_size == SIZE_HALF) && off[0])
                   || ((a_size == SIZE_WORD) && (off[1:0] != 2'b00));
`else
   assign mis_err   = 1'b0;
`endif
   assign err       = range_err || size_err || mis_err;
   assign idx       = off[AW+1:2];
   assign raw       = mem[idx];

   // Natural alignment: drop offset bits below the access size
   always_comb begin
      lane_off = off[1:0];
      if (a_size == SIZE_HALF) lane_off[0] = 1'b0;
      if (a_size == SIZE_WORD) lane_off = 2'b00;
   end

   dmem_lane_align u_align (
      .offset      (lane_off),
      .size        (a_size),
      .is_unsigned (a_uns),
      .wdata       (a_wdata),
      .raw         (raw),
      .byte_en     (byte_en),
      .wword       (wword),
      .rdata       (rd_ext)
   );

   // Next-state and countdown logic
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_nx = ST_RESP;
               end else begin
                  state_nx = ST_WAIT;
                  cnt_nx   = 4'(LATENCY - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) state_nx = ST_RESP;
            else             cnt_nx   = cnt - 4'd1;
         end
         ST_RESP: begin
            if (rsp_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // State, request latch and registered response
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         q_write   <= 1'b0;
         q_addr    <= 32'h0;
         q_wdata   <= 32'h0;
         q_size    <= 2'd0;
         q_uns     <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            q_write <= req_write;
            q_addr  <= req_addr;
            q_wdata <= req_wdata;
            q_size  <= req_size;
            q_uns   <= req_unsigned;
         end
         if (commit) begin
            rsp_err   <= err;
            rsp_rdata <= (err || a_write) ? 32'h0 : rd_ext;
         end
      end
   end

   // Storage write; contents survive reset
   always_ff @(posedge clock) begin
      if (!reset && commit && !err && a_write) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder (LATENCY=1).
// Misaligned-load expectation follows DMEM_MISALIGN_CHECK_EN.
module tb_dmem_responder;

   localparam int LAT = 1;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   dmem_responder #(
      .BASE_ADDR   (32'h0100_0000),
      .DEPTH_BYTES (65536),
      .LATENCY     (LAT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] er;
      logic        ee;
   } vec_t;

   localparam int NV = 18;
   vec_t v [NV];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue a request and wait for the response; rsp_ready is left low
   task automatic issue(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] sz,
                        input logic uns, output int lat);
      int n;
      @(negedge clock);
      req_valid    = 1'b1;
      req_write    = wr;
      req_addr     = addr;
      req_wdata    = wd;
      req_size     = sz;
      req_unsigned = uns;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: req_ready stuck low");
      end
      @(posedge clock);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!rsp_valid && lat < 40);
   endtask

   task automatic retire();
      rsp_ready = 1'b1;
      @(posedge clock);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic txn(input string name, input vec_t t);
      int lat;
      issue(t.wr, t.addr, t.wd, t.sz, t.uns, lat);
      chk({name, "_lat"}, 32'(lat), 32'(LAT + 1));
      chk({name, "_rdata"}, rsp_rdata, t.er);
      chk({name, "_err"}, {31'h0, rsp_err}, {31'h0, t.ee});
      retire();
   endtask

   initial begin
      int lat;
      v[0]  = '{1'b1, 32'h0100_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0,         1'b0};
      v[1]  = '{1'b0, 32'h0100_0010, 32'h0,         2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0};
      v[2]  = '{1'b0, 32'h0100_0013, 32'h0,         2'd0, 1'b0, 32'hFFFF_FFDE, 1'b0};
      v[3]  = '{1'b0, 32'h0100_0013, 32'h0,         2'd0, 1'b1, 32'h0000_00DE, 1'b0};
      v[4]  = '{1'b0, 32'h0100_0010, 32'h0,         2'd1, 1'b0, 32'hFFFF_BEEF, 1'b0};
      v[5]  = '{1'b1, 32'h0100_0011, 32'h0000_0055, 2'd0, 1'b0, 32'h0,         1'b0};
      v[6]  = '{1'b0, 32'h0100_0010, 32'h0,         2'd2, 1'b0, 32'hDEAD_55EF, 1'b0};
      v[7]  = '{1'b0, 32'h00FF_FFFC, 32'h0,         2'd2, 1'b0, 32'h0,         1'b1};
      v[8]  = '{1'b0, 32'h0101_0000, 32'h0,         2'd2, 1'b0, 32'h0,         1'b1};
      v[9]  = '{1'b0, 32'h0100_0010, 32'h0,         2'd2, 1'b0, 32'hDEAD_55EF, 1'b0};
`ifdef DMEM_MISALIGN_CHECK_EN
      v[10] = '{1'b0, 32'h0100_0012, 32'h0,         2'd2, 1'b0, 32'h0,         1'b1};
      v[11] = '{1'b0, 32'h0100_0011, 32'h0,         2'd1, 1'b0, 32'h0,         1'b1};
`else
      v[10] = '{1'b0, 32'h0100_0012, 32'h0,         2'd2, 1'b0, 32'hDEAD_55EF, 1'b0};
      v[11] = '{1'b0, 32'h0100_0011, 32'h0,         2'd1, 1'b0, 32'h0000_55EF, 1'b0};
`endif
      v[12] = '{1'b1, 32'h0100_0010, 32'h1111_1111, 2'd3, 1'b0, 32'h0,         1'b1};
      v[13] = '{1'b0, 32'h0100_0010, 32'h0,         2'd2, 1'b0, 32'hDEAD_55EF, 1'b0};
      v[14] = '{1'b0, 32'h0100_0012, 32'h0,         2'd1, 1'b1, 32'h0000_DEAD, 1'b0};
      v[15] = '{1'b1, 32'h0100_FFFC, 32'h1234_5678, 2'd2, 1'b0, 32'h0,         1'b0};
      v[16] = '{1'b0, 32'h0100_FFFF, 32'h0,         2'd0, 1'b1, 32'h0000_0012, 1'b0};
      v[17] = '{1'b1, 32'h0100_0020, 32'h0BAD_F00D, 2'd2, 1'b0, 32'h0,         1'b0};

      reset        = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      rsp_ready    = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

      for (int i = 0; i < NV; i++) begin
         txn($sformatf("vec%0d", i), v[i]);
      end

      // Backpressure: response held for five cycles
      issue(1'b0, 32'h0100_0010, 32'h0, 2'd2, 1'b0, lat);
      chk("bp_lat", 32'(lat), 32'(LAT + 1));
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_valid%0d", c), {31'h0, rsp_valid}, 32'h1);
         chk($sformatf("bp_rdata%0d", c), rsp_rdata, 32'hDEAD_55EF);
         chk($sformatf("bp_ready%0d", c), {31'h0, req_ready}, 32'h0);
         @(negedge clock);
      end
      retire();

      // Reset during WAIT of a store drops the store
      @(negedge clock);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0100_0020;
      req_wdata = 32'hCAFE_0001;
      req_size  = 2'd2;
      chk("rw_ready", {31'h0, req_ready}, 32'h1);
      @(posedge clock);
      #1 req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rw_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rw_req_ready", {31'h0, req_ready}, 32'h1);
      txn("rw_load", '{1'b0, 32'h0100_0020, 32'h0, 2'd2, 1'b0,
                       32'h0BAD_F00D, 1'b0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the five-stage RISC-V core: the far end of the core's load/store path. Accepts one byte/half/word load or store request at a time over a valid/ready handshake, models a configurable access latency, and returns aligned, sign- or zero-extended read data with an error flag. Sits between the memory stage and a private byte-addressed storage array. Replaces the zero-wait combinational data memory in latency-tolerant builds.

## Interface
- `BASE_ADDR`, 32'h01000000, first byte address served
- `DEPTH_BYTES`, 65536, storage size in bytes; power of two, multiple of 4
- `LATENCY`, 1, cycles spent in WAIT; range 0..15

- `clock`  in  1  sole clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept a request
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 = illegal
- `req_unsigned`  in  1  load zero-extends when 1 (funct3[2]); sign-extends when 0
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes the response
- `rsp_rdata`  out  32  load result; 0 for stores and errors
- `rsp_err`  out  1  access faulted; no storage change

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch write, addr, wdata, size, and unsigned.
  - If `LATENCY`==0, go to RESP.
  - Otherwise load the countdown with `LATENCY`-1 and go to WAIT.
- WAIT: decrement the countdown. At 0, commit the access and go to RESP.
- With `LATENCY`==0, the commit occurs on the accept edge.
- Commit:
  - Evaluate the error conditions: out of range (addr < `BASE_ADDR` or addr−`BASE_ADDR` ≥ `DEPTH_BYTES`), `req_size`==3, or misalignment (see Configuration).
  - On error, `rsp_err`=1, `rsp_rdata`=0, and storage is untouched.
  - Store: write the low 1/2/4 bytes of wdata little-endian at the offset. `rsp_rdata`=0.
  - Load: read the bytes and extend to 32 bits per size and unsigned. Word loads ignore unsigned.
- RESP: `rsp_valid`=1 and the outputs are stable. On `rsp_ready`, go to IDLE.
- Offset arithmetic is 32-bit unsigned. Wrap-around in addr−BASE is impossible because the lower bound is checked first.

## Timing
- Reset values: `req_ready`=0 during the reset cycle, then 1. `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE, countdown 0.
- Storage contents are not cleared by reset.
- Reset mid-operation: return to IDLE. A store not yet committed is dropped. A pending response is discarded.
- Request-to-response latency is `LATENCY`+1 cycles: accept edge to the first cycle with `rsp_valid` high.
- Peak throughput is one access per `LATENCY`+2 cycles when `rsp_ready` is held high. The RESP→IDLE edge costs one cycle.
- `req_ready` is combinational from the state only, never from `req_valid`.
- When `rsp_valid` and `rsp_ready` are both high, the response retires on that edge. No new request is accepted in that same cycle.

## Configuration
- `DMEM_MISALIGN_CHECK_EN`, when defined: a half access with addr[0]≠0, or a word access with addr[1:0]≠0, sets `rsp_err` and is not performed.
- When undefined: low address bits below the access size are forced to 0 (natural alignment), the access proceeds, and `rsp_err` reflects only range and illegal-size faults.

## Structure
- Shared package `dmem_pkg`:
  - size encodings `SIZE_BYTE`/`SIZE_HALF`/`SIZE_WORD`
  - FSM state type (`ST_IDLE`, `ST_WAIT`, `ST_RESP`)
  - default `BASE_ADDR` constant, shared with the fetch-side memory
- One combinational sub-module, `dmem_lane_align`:
  - Inputs: offset[1:0], size, unsigned, wdata, and the raw word.
  - Outputs: byte-enable mask, shifted write word, and the extracted/extended read value.
- Storage is a byte array (or a 4-lane word array) in the top module.

## Test plan
- `LATENCY`=1: store word 0xDEADBEEF at 0x01000010, then load word from 0x01000010. Expect `rsp_valid` 2 cycles after each accept, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Load byte from 0x01000013 with unsigned=0 → 0xFFFFFFDE. Same with unsigned=1 → 0x000000DE. Load half from 0x01000010 with unsigned=0 → 0xFFFFBEEF.
- Store byte 0x55 to 0x01000011, then load word from 0x01000010 → 0xDEAD55EF.
- Load from 0x00FFFFFC and from 0x01010000 (`DEPTH_BYTES`=65536) → `rsp_err`=1, `rsp_rdata`=0. A following valid load returns the prior contents unchanged.
- Load word from 0x01000012: with `DMEM_MISALIGN_CHECK_EN` → `rsp_err`=1; without it → returns the word at 0x01000010, `rsp_err`=0.
- Backpressure and reset:
  - Hold `rsp_ready`=0 for 5 cycles → `rsp_valid`/`rsp_rdata` stable and `req_ready`=0 throughout.
  - Assert `reset` during WAIT of a store to 0x01000020 → next load of 0x01000020 returns the old value.
